// File: rtl/vend_pkg.sv
// ---------------------------------------------------------------------------
// vend_pkg : shared vending-machine encodings, coin values and FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vend_pkg;

   typedef enum logic [1:0] {
      COIN_1  = 2'd0,
      COIN_5  = 2'd1,
      COIN_10 = 2'd2,
      COIN_50 = 2'd3
   } coin_t;

   localparam logic [7:0] COIN_VAL [4] = '{8'd1, 8'd5, 8'd10, 8'd50};

   localparam logic [7:0] PRICE_WATER = 8'd20;
   localparam logic [7:0] PRICE_TEA   = 8'd35;
   localparam logic [7:0] PRICE_COLA  = 8'd45;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_REQ    = 3'd2,
      ST_DONE   = 3'd3,
      ST_FAULT  = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/coin_select.sv
// ---------------------------------------------------------------------------
// coin_select : greedy picker, largest in-stock coin not exceeding remain
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module coin_select
   import vend_pkg::*;
#(
   parameter int INV_W = 8
) (
   input  logic [7:0]            i_remain,
   input  logic [3:0][INV_W-1:0] i_inv_cnt,
   output logic                  o_found,
   output logic [1:0]            o_type
);

   // Ascending scan: the last qualifying denomination is the largest one.
   always_comb begin
      o_found = 1'b0;
      o_type  = COIN_1;
      for (int d = 0; d < 4; d++) begin
         if ((COIN_VAL[d] <= i_remain) && (i_inv_cnt[d] != '0)) begin
            o_found = 1'b1;
            o_type  = 2'(d);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/change_dispense_ctrl.sv
// ---------------------------------------------------------------------------
// change_dispense_ctrl : pays change one coin at a time via the hopper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module change_dispense_ctrl
   import vend_pkg::*;
#(
   parameter int INV_W       = 8,
   parameter int INIT_CNT50  = 4,
   parameter int INIT_CNT10  = 4,
   parameter int INIT_CNT5   = 4,
   parameter int INIT_CNT1   = 4,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               chg_valid,
   input  logic [7:0]         chg_amount,
   output logic               chg_ready,
   output logic               coin_req,
   output logic [1:0]         coin_type,
   input  logic               coin_ack,
   input  logic               refill_en,
   input  logic [1:0]         refill_sel,
   input  logic [INV_W-1:0]   refill_cnt,
   output logic [4*INV_W-1:0] inv_cnt,
   output logic               done,
   output logic               fault,
   output logic [7:0]         short_amt
);

   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

   state_t                r_state, w_next;
   logic [7:0]            r_remain;
   logic [1:0]            r_type;
   logic                  r_coin_req, r_done, r_fault;
   logic [7:0]            r_short;
   logic [TO_W-1:0]       r_to;
   logic [3:0][INV_W-1:0] r_cnt;

   logic                  w_found;
   logic [1:0]            w_sel_type;
   logic                  w_accept, w_ack, w_timeout;
   logic [INV_W:0]        w_sum;
   logic [INV_W-1:0]      w_sat;

   coin_select #(.INV_W(INV_W)) u_coin_select (
      .i_remain  (r_remain),
      .i_inv_cnt (r_cnt),
      .o_found   (w_found),
      .o_type    (w_sel_type)
   );

   assign w_accept  = (r_state == ST_IDLE) && chg_valid;
   assign w_ack     = (r_state == ST_REQ) && coin_ack;
   assign w_timeout = (r_state == ST_REQ) && !coin_ack && (r_to == TO_W'(ACK_TIMEOUT - 1));
   assign w_sum     = {1'b0, r_cnt[refill_sel]} + {1'b0, refill_cnt};
   assign w_sat     = w_sum[INV_W] ? '1 : w_sum[INV_W-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (chg_valid) w_next = (chg_amount == 8'd0) ? ST_DONE : ST_SELECT;
         ST_SELECT: w_next = w_found ? ST_REQ : ST_FAULT;
         ST_REQ: begin
            if (coin_ack)       w_next = (r_remain == COIN_VAL[r_type]) ? ST_DONE : ST_SELECT;
            else if (w_timeout) w_next = ST_FAULT;
         end
         ST_DONE:   w_next = ST_IDLE;
         ST_FAULT:  w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_remain   <= 8'd0;
         r_type     <= 2'd0;
         r_coin_req <= 1'b0;
         r_done     <= 1'b0;
         r_fault    <= 1'b0;
         r_short    <= 8'd0;
         r_to       <= '0;
         r_cnt[3]   <= INV_W'(INIT_CNT50);
         r_cnt[2]   <= INV_W'(INIT_CNT10);
         r_cnt[1]   <= INV_W'(INIT_CNT5);
         r_cnt[0]   <= INV_W'(INIT_CNT1);
      end else begin
         r_done  <= (r_state == ST_DONE) || (r_state == ST_FAULT);
         r_fault <= (r_state == ST_FAULT);
         if (w_accept) begin
            r_remain <= chg_amount;
            r_short  <= 8'd0;
         end
         if (r_state == ST_FAULT) r_short <= r_remain;
         if ((r_state == ST_SELECT) && w_found) begin
            r_coin_req <= 1'b1;
            r_type     <= w_sel_type;
            r_to       <= '0;
         end
         // Selected value never exceeds remain, so the subtraction cannot wrap.
         if (w_ack) begin
            r_coin_req    <= 1'b0;
            r_remain      <= r_remain - COIN_VAL[r_type];
            r_cnt[r_type] <= r_cnt[r_type] - INV_W'(1);
         end else if (w_timeout) begin
            r_coin_req <= 1'b0;
         end else if (r_state == ST_REQ) begin
            r_to <= r_to + TO_W'(1);
         end
         if ((r_state == ST_IDLE) && refill_en) r_cnt[refill_sel] <= w_sat;
      end
   end

   assign chg_ready = (r_state == ST_IDLE);
   assign coin_req  = r_coin_req;
   assign coin_type = r_type;
   assign inv_cnt   = r_cnt;
   assign done      = r_done;
   assign fault     = r_fault;
   assign short_amt = r_short;

endmodule

`default_nettype wire

// File: tb/tb_change_dispense_ctrl.sv
// ---------------------------------------------------------------------------
// tb_change_dispense_ctrl : directed table plus corner sequences
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_change_dispense_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        chg_valid;
   logic [7:0]  chg_amount;
   logic        chg_ready;
   logic        coin_req;
   logic [1:0]  coin_type;
   logic        coin_ack;
   logic        refill_en;
   logic [1:0]  refill_sel;
   logic [7:0]  refill_cnt;
   logic [31:0] inv_cnt;
   logic        done;
   logic        fault;
   logic [7:0]  short_amt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   change_dispense_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .chg_valid  (chg_valid),
      .chg_amount (chg_amount),
      .chg_ready  (chg_ready),
      .coin_req   (coin_req),
      .coin_type  (coin_type),
      .coin_ack   (coin_ack),
      .refill_en  (refill_en),
      .refill_sel (refill_sel),
      .refill_cnt (refill_cnt),
      .inv_cnt    (inv_cnt),
      .done       (done),
      .fault      (fault),
      .short_amt  (short_amt)
   );

   typedef struct {
      logic [7:0]  amount;
      int          ncoins;
      logic [11:0] coins;
      logic        exp_fault;
      logic [7:0]  exp_short;
      logic [31:0] exp_inv;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Accept one request, ack every coin on sight, return what the DUT reported.
   task automatic run_request(input logic [7:0] amt, output int ncoins,
                              output logic [11:0] coins, output logic got_done,
                              output logic got_fault, output logic [7:0] got_short);
      ncoins = 0; coins = '0; got_done = 1'b0; got_fault = 1'b0; got_short = '0;
      @(negedge clk);
      chg_valid = 1'b1; chg_amount = amt;
      @(negedge clk);
      chg_valid = 1'b0;
      for (int c = 0; c < 200 && !got_done; c++) begin
         coin_ack = 1'b0;
         if (coin_req) begin
            coin_ack = 1'b1;
            if (ncoins < 6) coins[2*ncoins +: 2] = coin_type;
            ncoins++;
         end
         if (done) begin
            got_done = 1'b1; got_fault = fault; got_short = short_amt;
         end
         if (!got_done) @(negedge clk);
      end
      coin_ack = 1'b0;
   endtask

   initial begin
      int          nc;
      logic [11:0] cs;
      logic        gd, gf;
      logic [7:0]  gs;
      int          req_cycles;

      vecs[0] = '{8'd41, 5, 12'h0AA, 1'b0, 8'd0, 32'h04000403};
      vecs[1] = '{8'd0,  0, 12'h000, 1'b0, 8'd0, 32'h04000403};
      vecs[2] = '{8'd4,  3, 12'h000, 1'b1, 8'd1, 32'h04000400};
      vecs[3] = '{8'd63, 3, 12'h017, 1'b1, 8'd3, 32'h03000200};
      vecs[4] = '{8'd7,  1, 12'h001, 1'b1, 8'd2, 32'h03000100};

      reset = 1'b0; chg_valid = 1'b0; chg_amount = '0; coin_ack = 1'b0;
      refill_en = 1'b0; refill_sel = '0; refill_cnt = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(chg_ready), 32'd1);
      check("rst_coin_req", 32'(coin_req), 32'd0);
      check("rst_coin_type", 32'(coin_type), 32'd0);
      check("rst_done_fault", {30'd0, done, fault}, 32'd0);
      check("rst_short", 32'(short_amt), 32'd0);
      check("rst_inv", inv_cnt, 32'h04040404);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run_request(vecs[i].amount, nc, cs, gd, gf, gs);
         check($sformatf("v%0d_done", i), 32'(gd), 32'd1);
         check($sformatf("v%0d_ncoins", i), 32'(nc), 32'(vecs[i].ncoins));
         check($sformatf("v%0d_coins", i), 32'(cs), 32'(vecs[i].coins));
         check($sformatf("v%0d_fault", i), 32'(gf), 32'(vecs[i].exp_fault));
         check($sformatf("v%0d_short", i), 32'(gs), 32'(vecs[i].exp_short));
         check($sformatf("v%0d_inv", i), inv_cnt, vecs[i].exp_inv);
      end

      // Zero amount: done exactly two cycles after accept, no coin request.
      @(negedge clk);
      chg_valid = 1'b1; chg_amount = 8'd0;
      @(negedge clk);
      chg_valid = 1'b0;
      check("zero_c1_done", {30'd0, done, coin_req}, 32'd0);
      @(negedge clk);
      check("zero_c2_done", {29'd0, done, fault, coin_req}, 32'b100);

      // Timeout: 50 with no ack; stray ack, late request and refill are ignored.
      @(negedge clk);
      chg_valid = 1'b1; chg_amount = 8'd50;
      @(negedge clk);
      chg_amount = 8'd5; coin_ack = 1'b1;
      check("to_select_req", 32'(coin_req), 32'd0);
      @(negedge clk);
      chg_valid = 1'b0; coin_ack = 1'b0;
      refill_en = 1'b1; refill_sel = 2'd3; refill_cnt = 8'd10;
      check("to_latency_req", {30'd0, coin_req, chg_ready}, 32'b10);
      check("to_type", 32'(coin_type), 32'd3);
      req_cycles = 1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         refill_en = 1'b0;
         if (!coin_req) break;
         req_cycles++;
      end
      check("to_req_cycles", 32'(req_cycles), 32'd15);
      @(negedge clk);
      check("to_done_fault", {30'd0, done, fault}, 32'b11);
      check("to_short", 32'(short_amt), 32'd50);
      check("to_inv", inv_cnt, 32'h03000100);
      @(negedge clk);
      check("to_short_held", 32'(short_amt), 32'd50);

      // Reset while a coin is requested.
      chg_valid = 1'b1; chg_amount = 8'd10;
      @(negedge clk);
      chg_valid = 1'b0;
      @(negedge clk);
      check("rr_req_before", 32'(coin_req), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("rr_req_now", 32'(coin_req), 32'd0);
      check("rr_inv", inv_cnt, 32'h04040404);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rr_ready", {30'd0, chg_ready, done}, 32'b10);

      // Refill in IDLE, saturation, and refill on the accept cycle.
      refill_en = 1'b1; refill_sel = 2'd1; refill_cnt = 8'd250;
      @(negedge clk);
      check("rf_add", inv_cnt, 32'h0404FE04);
      @(negedge clk);
      refill_en = 1'b0;
      check("rf_sat", inv_cnt, 32'h0404FF04);
      chg_valid = 1'b1; chg_amount = 8'd0;
      refill_en = 1'b1; refill_sel = 2'd0; refill_cnt = 8'd1;
      @(negedge clk);
      chg_valid = 1'b0; refill_en = 1'b0;
      @(negedge clk);
      check("rf_accept_done", 32'(done), 32'd1);
      check("rf_accept_inv", inv_cnt, 32'h0404FF05);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

`default_nettype wire
